// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I sequencer.
//   state_t      : 3-bit phase encoding, also exported on state_o
//   CLS_*        : bit positions inside the latched instruction-class vector
package ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    PCUPD  = 3'd5,
    HALTED = 3'd6,
    FAULT  = 3'd7
  } state_t;

  localparam int CLS_W        = 4;
  localparam int CLS_REGWRITE = 0;
  localparam int CLS_MEMWRITE = 1;
  localparam int CLS_MEMREAD  = 2;
  localparam int CLS_BRANCH   = 3;

endpackage

// File: rtl/ctrl_watchdog.sv
// Per-phase watchdog for the sequencer.
//   clk, rst : clock, synchronous active-high reset
//   clear    : pulse on every state change; restarts the count
//   active   : high while the sequencer sits in a timed phase
//   expired  : high in the cycle the phase has lasted TIMEOUT cycles
// The count holds the number of completed cycles spent in the current
// phase, so expired is raised during the TIMEOUT-th cycle. TIMEOUT=0
// disables the watchdog entirely.
module ctrl_watchdog #(
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic active,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (active && (count != '1)) begin
      // Saturate so a disabled watchdog never wraps back into range.
      count <= count + 1'b1;
    end
  end

  assign expired = (TIMEOUT != 0) && active && (count == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer for the RV32I core.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   halt                          : stop request, beats every other event
//   instr_fetched, id_comp,
//   mem_comp, wb_comp, pc_update  : per-phase done inputs
//   branch, memread, memwrite,
//   regwrite                      : instruction class, valid with id_comp
//   instrfetch, decode, mem, wb,
//   PCwrite                       : per-phase strobes
//   halted, fault                 : in HALTED / FAULT
//   state_o                       : current state encoding (debug)
//   retired                       : completed-instruction count (wraps)
//
// Handshake: a phase strobe is high for every cycle the sequencer is in
// that phase. The datapath block answers with a one-cycle done; the done
// is consumed in the cycle it is seen and the strobe drops on the next
// edge. A done seen outside its own phase is ignored.
//
// All outputs are registered from the next-state value, so they equal a
// decode of the state register with no input-to-output path.
module multicycle_ctrl
  import ctrl_pkg::*;
#(
  parameter bit MEM_EN  = 1'b1,
  parameter int TIMEOUT = 0,
  parameter int TO_W    = 8,
  parameter int RET_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt,
  input  logic             instr_fetched,
  input  logic             id_comp,
  input  logic             mem_comp,
  input  logic             wb_comp,
  input  logic             pc_update,
  input  logic             branch,
  input  logic             memread,
  input  logic             memwrite,
  input  logic             regwrite,
  output logic             instrfetch,
  output logic             decode,
  output logic             mem,
  output logic             wb,
  output logic             PCwrite,
  output logic             halted,
  output logic             fault,
  output logic [2:0]       state_o,
  output logic [RET_W-1:0] retired
);

  state_t             state;
  state_t             state_next;
  logic [CLS_W-1:0]   cls;
  logic               retire;
  logic               expired;
  logic               phase_active;
  logic               state_change;

  assign phase_active = (state != IDLE) && (state != HALTED) && (state != FAULT);
  assign state_change = (state_next != state);
  assign state_o      = state;

  ctrl_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (state_change),
    .active  (phase_active),
    .expired (expired)
  );

  // Priority inside a phase: halt, then done, then watchdog expiry.
  always_comb begin
    state_next = state;
    retire     = 1'b0;
    if (phase_active && halt) begin
      state_next = HALTED;
    end else if (state == IDLE && halt) begin
      state_next = HALTED;
    end else begin
      unique case (state)
        IDLE: state_next = FETCH;
        FETCH: begin
          if (instr_fetched)  state_next = DECODE;
          else if (expired)   state_next = FAULT;
        end
        DECODE: begin
          if (id_comp) begin
            if (MEM_EN && (memread || memwrite)) state_next = MEM;
            else if (branch)                     state_next = PCUPD;
            else if (regwrite)                   state_next = WB;
            else                                 state_next = PCUPD;
          end else if (expired) begin
            state_next = FAULT;
          end
        end
        MEM: begin
          // Only the latched class is used past DECODE.
          if (mem_comp) begin
            if (cls[CLS_MEMREAD] && cls[CLS_REGWRITE]) state_next = WB;
            else                                       state_next = PCUPD;
          end else if (expired) begin
            state_next = FAULT;
          end
        end
        WB: begin
          if (wb_comp)        state_next = PCUPD;
          else if (expired)   state_next = FAULT;
        end
        PCUPD: begin
          if (pc_update) begin
            state_next = FETCH;
            retire     = 1'b1;
          end else if (expired) begin
            state_next = FAULT;
          end
        end
        HALTED:  state_next = HALTED;
        FAULT:   state_next = FAULT;
        default: state_next = FAULT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cls        <= '0;
      retired    <= '0;
      instrfetch <= 1'b0;
      decode     <= 1'b0;
      mem        <= 1'b0;
      wb         <= 1'b0;
      PCwrite    <= 1'b0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      state <= state_next;
      if (state == DECODE && id_comp && !halt) begin
        cls[CLS_BRANCH]   <= branch;
        cls[CLS_MEMREAD]  <= memread;
        cls[CLS_MEMWRITE] <= memwrite;
        cls[CLS_REGWRITE] <= regwrite;
      end
      if (retire) begin
        retired <= retired + 1'b1;
      end
      instrfetch <= (state_next == FETCH);
      decode     <= (state_next == DECODE);
      mem        <= MEM_EN && (state_next == MEM);
      wb         <= (state_next == WB);
      PCwrite    <= (state_next == PCUPD);
      halted     <= (state_next == HALTED);
      fault      <= (state_next == FAULT);
    end
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Parametrised multi-cycle sequencer for the RV32I core.
- Steps each instruction through FETCH, DECODE, optional MEM, WB and PC-update phases, using a per-phase strobe/done handshake with the datapath blocks.
- Adds four features:
  - a real MEM phase, selectable by parameter;
  - latched instruction class;
  - per-phase watchdog with a sticky FAULT state;
  - retired-instruction counter.

Parameters:
MEM_EN, 1, 1 = loads/stores visit MEM phase; 0 = they skip it (DECODE goes straight to WB/PC).
TIMEOUT, 0, max cycles allowed in one phase without its done; 0 disables the watchdog.
TO_W, 8, width of the watchdog counter; TIMEOUT must be < 2^TO_W.
RET_W, 32, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
halt  in  1  stop request; highest priority
instr_fetched  in  1  fetch phase complete
id_comp  in  1  decode phase complete; class inputs valid this cycle
mem_comp  in  1  memory phase complete
wb_comp  in  1  write-back phase complete
pc_update  in  1  PC register written
branch  in  1  class: branch/jump
memread  in  1  class: load
memwrite  in  1  class: store
regwrite  in  1  class: writes rd
instrfetch  out  1  fetch strobe
decode  out  1  decode strobe
mem  out  1  memory strobe
wb  out  1  write-back strobe
PCwrite  out  1  PC update strobe
halted  out  1  in HALTED state
fault  out  1  in FAULT state
state_o  out  3  current state encoding
retired  out  RET_W  count of completed instructions

Behaviour:
- State encodings: IDLE=0, FETCH=1, DECODE=2, MEM=3, WB=4, PCUPD=5, HALTED=6, FAULT=7. State register only; all outputs are decoded from registered state or counters, so there are no combinational input-to-output paths.
- Reset:
  - state=IDLE, retired=0, watchdog=0, class latch=0.
  - All strobes 0, halted=0, fault=0.
  - Reset mid-phase aborts that phase immediately.
- IDLE: one cycle, then FETCH (or HALTED if halt=1).
- Strobes: each strobe is 1 for every cycle its state is held, including the cycle its done is seen. It drops on the edge that leaves the state, one clock after done.
- FETCH: on instr_fetched, go to DECODE.
- DECODE: on id_comp:
  - latch {branch, memread, memwrite, regwrite};
  - if MEM_EN and (memread or memwrite), go to MEM;
  - else if branch, go to PCUPD;
  - else if regwrite, go to WB;
  - else go to PCUPD.
  Later phases use only the latched class, never the live class inputs.
- MEM: on mem_comp, go to WB if latched memread and regwrite; otherwise go to PCUPD.
- WB: on wb_comp, go to PCUPD.
- PCUPD: on pc_update, go to FETCH and increment retired by 1. retired wraps modulo 2^RET_W.
- Done inputs seen outside their own state are ignored.
- halt:
  - In any state 0..5, halt=1 goes to HALTED on the next edge, even if a done is asserted in the same cycle. No retire is counted in that case.
  - HALTED: all strobes 0, halted=1. Exit only via rst.
- Watchdog (TIMEOUT>0):
  - Counter clears on every state change and increments in each cycle the state is held in states 1..5.
  - If the counter reaches TIMEOUT while done is still 0, go to FAULT.
  - If done arrives in the same cycle the counter reaches TIMEOUT, done wins.
  - halt beats timeout.
- FAULT: all strobes 0, fault=1, sticky until rst. halt has no effect in FAULT.
- MEM_EN=0: MEM state is unreachable and mem is held at 0.

Decomposition:
- Shared package ctrl_pkg holds:
  - state encoding constants (IDLE..FAULT, 3 bits);
  - class-bit index constants.
- Sub-module ctrl_watchdog (parameters TIMEOUT, TO_W) takes inputs clear and active and produces output expired. Its clear is driven by the state-change pulse.
- The rest is a single FSM plus counters in one module.

Test Plan:
- ALU instruction (regwrite=1, branch=0): each done pulsed 1 cycle after its strobe rises. States go 1→2→4→5→1; retired goes 0→1; each strobe is high exactly 2 cycles.
- Load with MEM_EN=1 (memread=regwrite=1): path 2→3→4→5. Class inputs flip to 0 after id_comp, yet WB is still entered.
- Store with MEM_EN=1: path 2→3→5 with wb never asserted. With MEM_EN=0 the same store goes 2→5 and mem stays 0.
- halt asserted in WB together with wb_comp: next state is 6, halted=1, all strobes 0, retired unchanged. halt then deasserts and the state stays 6 until rst.
- TIMEOUT=4, instr_fetched held 0: FAULT is entered after instrfetch has been high for 4 cycles; fault=1. A second run with instr_fetched asserted on the 4th cycle goes to DECODE instead.
- Run 3 instructions with RET_W=2, then apply rst in DECODE: retired reads 3, then after rst reads 0 with state 0, and 2 cycles later the state is FETCH.
